// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback, stalls on MemReady with a watchdog, and parks in a sticky fault state.
module multicycle_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Fault,
    output logic [1:0] FaultCause,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        FAULT    = 4'd11
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_r;
    state_t     base_next_s;
    state_t     next_s;
    logic [7:0] wait_cnt_r;
    logic [1:0] cause_r;
    logic [1:0] base_cause_s;
    logic [1:0] next_cause_s;
    logic [1:0] alu_op_s;
    logic       waiting_s;
    logic       timeout_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       reg_write_s;
    logic       mem_write_s;

    assign waiting_s = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);
    // Ready wins over timeout: only a cycle with MemReady low at the limit faults.
    assign timeout_s = waiting_s && !MemReady && (wait_cnt_r == TIMEOUT_CNT);

    // Next-state and fault-cause selection.
    always_comb begin
        base_next_s  = state_r;
        base_cause_s = cause_r;
        case (state_r)
            FETCH:    base_next_s = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: base_next_s = MEMADR;
                    7'b0110011:             base_next_s = EXECR;
                    7'b0010011:             base_next_s = EXECI;
                    7'b1101111:             base_next_s = JAL;
                    7'b1100011:             base_next_s = BEQ;
                    default: begin
                        base_next_s  = FAULT;
                        base_cause_s = 2'b01;
                    end
                endcase
            end
            MEMADR:   base_next_s = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  base_next_s = MemReady ? MEMWB : MEMREAD;
            MEMWB:    base_next_s = FETCH;
            MEMWRITE: base_next_s = MemReady ? FETCH : MEMWRITE;
            EXECR:    base_next_s = ALUWB;
            EXECI:    base_next_s = ALUWB;
            ALUWB:    base_next_s = FETCH;
            JAL:      base_next_s = ALUWB;
            BEQ:      base_next_s = FETCH;
            FAULT:    base_next_s = FAULT;
            default:  base_next_s = FETCH;
        endcase
        next_s       = timeout_s ? FAULT : base_next_s;
        next_cause_s = timeout_s ? 2'b10 : base_cause_s;
    end

    // State, wait counter and sticky fault cause registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= FETCH;
            wait_cnt_r <= 8'd0;
            cause_r    <= 2'b00;
        end else begin
            state_r <= next_s;
            cause_r <= next_cause_s;
            if (waiting_s && (next_s == state_r)) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
        end
    end

    // Per-state datapath selects and raw write enables.
    always_comb begin
        ImmSrc      = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        AdrSrc      = 1'b0;
        alu_op_s    = 2'b00;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
        case (state_r)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_s = MemReady;
                pc_write_s = MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = !timeout_s;
            end
            EXECR: begin
                ALUSrcA  = 2'b10;
                alu_op_s = 2'b10;
            end
            EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                alu_op_s = 2'b10;
            end
            ALUWB:    reg_write_s = 1'b1;
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_s = 1'b1;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op_s   = 2'b01;
                pc_write_s = Zero;
            end
            default: begin
                ALUSrcA = 2'b00;
            end
        endcase
    end

    // ALU operation decode from ALUOp and the funct fields.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op_s)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Enables are suppressed combinationally while reset is asserted.
    assign IRWrite    = ir_write_s && !reset;
    assign PCWrite    = pc_write_s && !reset;
    assign RegWrite   = reg_write_s && !reset;
    assign MemWrite   = mem_write_s && !reset;
    assign Fault      = (state_r == FAULT);
    assign FaultCause = cause_r;
    assign State      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an instruction-level model pushes one expected control vector per
// cycle; a monitor on the falling edge pops and compares it with the DUT outputs.
module tb_multicycle_controller;

    localparam int TO = 7;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, FaultCause;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Fault;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic [22:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_cyc = 0;
    logic [6:0]  cur_op = 7'd0;
    logic [2:0]  cur_f3 = 3'd0;
    logic        cur_f7 = 1'b0;
    logic [1:0]  cause_m = 2'b00;

    multicycle_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Fault(Fault), .FaultCause(FaultCause), .State(State)
    );

    always #5 clk = ~clk;

    // Expected control vector for one cycle of a given phase, straight from the state table.
    function automatic logic [22:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic rdy,
                                          input logic tmo, input logic [1:0] cause);
        logic [1:0] imm, a, b, res, aluop;
        logic       adr, irw, pcw, rw, mw, flt;
        logic [2:0] alu;
        imm = 2'b00; a = 2'b00; b = 2'b00; res = 2'b00; aluop = 2'b00;
        adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; flt = 1'b0;
        if (o == 7'b0100011) imm = 2'b01;
        else if (o == 7'b1100011) imm = 2'b10;
        else if (o == 7'b1101111) imm = 2'b11;
        case (st)
            0:  begin b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  adr = 1'b1;
            4:  begin res = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = !tmo; end
            6:  begin a = 2'b10; aluop = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; aluop = 2'b10; end
            8:  rw = 1'b1;
            9:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            10: begin a = 2'b10; aluop = 2'b01; pcw = z; end
            default: flt = 1'b1;
        endcase
        if (aluop == 2'b01) alu = 3'b001;
        else if (aluop == 2'b00) alu = 3'b000;
        else if (f3 == 3'b000) alu = (o[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) alu = 3'b101;
        else if (f3 == 3'b110) alu = 3'b011;
        else if (f3 == 3'b111) alu = 3'b010;
        else alu = 3'b000;
        return {4'(st), imm, a, b, res, adr, alu, irw, pcw, rw, mw, flt, cause};
    endfunction

    // Monitor: compare the DUT outputs with the queued expectation each falling edge.
    always @(negedge clk) begin
        logic [22:0] e, act;
        n_cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {State, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                   IRWrite, PCWrite, RegWrite, MemWrite, Fault, FaultCause};
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL ctrl_vec cycle %0d: actual state %0d vec %h, required state %0d vec %h",
                         n_cyc, act[22:19], act, e[22:19], e);
            end
        end
    end

    task automatic cyc(input int st, input logic rdy, input logic z, input logic tmo);
        @(posedge clk);
        #1;
        reset = 1'b0; op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
        MemReady = rdy; Zero = z;
        exp_q.push_back(model(st, cur_op, cur_f3, cur_f7, z, rdy, tmo, cause_m));
    endtask

    task automatic do_reset(input int n);
        cause_m = 2'b00;
        repeat (n) begin
            @(posedge clk);
            #1;
            reset = 1'b1; op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
            MemReady = 1'b0; Zero = 1'($urandom_range(0, 1));
            exp_q.push_back(model(0, cur_op, cur_f3, cur_f7, Zero, 1'b0, 1'b0, 2'b00));
        end
    endtask

    task automatic rcyc(input int st);
        cyc(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // A stalling state: MemReady low for nwait cycles; faults if still low at the limit.
    task automatic wait_phase(input int st, input int nwait, output bit flt);
        logic rdy, tmo;
        flt = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            rdy = (k >= nwait);
            tmo = (k == TO) && !rdy;
            cyc(st, rdy, 1'($urandom_range(0, 1)), tmo);
            if (rdy) break;
            if (tmo) begin
                flt = 1'b1;
                cause_m = 2'b10;
                break;
            end
        end
    endtask

    task automatic fault_phase();
        repeat (3) rcyc(11);
        do_reset(2);
    endtask

    task automatic run_instr(input int kind, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int fw, input int mw, input logic z);
        bit flt;
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
        wait_phase(0, fw, flt);
        if (flt) begin
            fault_phase();
            return;
        end
        rcyc(1);
        case (kind)
            K_R:   begin rcyc(6); rcyc(8); end
            K_I:   begin rcyc(7); rcyc(8); end
            K_LW: begin
                rcyc(2);
                wait_phase(3, mw, flt);
                if (flt) fault_phase();
                else rcyc(4);
            end
            K_SW: begin
                rcyc(2);
                wait_phase(5, mw, flt);
                if (flt) fault_phase();
            end
            K_JAL: begin rcyc(9); rcyc(8); end
            K_BEQ: cyc(10, 1'($urandom_range(0, 1)), z, 1'b0);
            default: begin
                cause_m = 2'b01;
                fault_phase();
            end
        endcase
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return r % 3;
        else if (r < 17) return TO;
        else return TO + 1;
    endfunction

    initial begin
        logic [6:0] o;
        int kind;
        do_reset(3);
        run_instr(K_R, 7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(K_LW, 7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0);
        run_instr(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1);
        run_instr(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(K_R, 7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr(K_I, 7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr(K_I, 7'b0010011, 3'b111, 1'b0, 0, 0, 1'b0);
        run_instr(K_I, 7'b0010011, 3'b010, 1'b0, 0, 0, 1'b0);
        run_instr(K_R, 7'b0110011, 3'b110, 1'b0, 1, 0, 1'b0);
        run_instr(K_JAL, 7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(K_ILL, 7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(K_SW, 7'b0100011, 3'b010, 1'b0, 0, TO + 1, 1'b0);
        run_instr(K_SW, 7'b0100011, 3'b010, 1'b0, 0, TO, 1'b0);
        run_instr(K_LW, 7'b0000011, 3'b010, 1'b0, 0, TO + 1, 1'b0);
        run_instr(K_R, 7'b0110011, 3'b000, 1'b0, TO + 1, 0, 1'b0);
        run_instr(K_R, 7'b0110011, 3'b000, 1'b0, TO, 0, 1'b0);
        // Reset asserted in the middle of a stalled store.
        cur_op = 7'b0100011; cur_f3 = 3'b010; cur_f7 = 1'b0;
        cyc(0, 1'b1, 1'b0, 1'b0);
        rcyc(1);
        rcyc(2);
        cyc(5, 1'b0, 1'b0, 1'b0);
        cyc(5, 1'b0, 1'b1, 1'b0);
        do_reset(2);
        #2;
        if (State !== 4'd0 || MemWrite !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_store: actual state %0d MemWrite %b, required state 0 MemWrite 0",
                     State, MemWrite);
        end
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                K_R:   o = 7'b0110011;
                K_I:   o = 7'b0010011;
                K_LW:  o = 7'b0000011;
                K_SW:  o = 7'b0100011;
                K_JAL: o = 7'b1101111;
                K_BEQ: o = 7'b1100011;
                default: begin
                    o = 7'($urandom);
                    while (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
                           o == 7'b0100011 || o == 7'b1101111 || o == 7'b1100011)
                        o = 7'($urandom);
                end
            endcase
            run_instr(kind, o, 3'($urandom), 1'($urandom), rand_wait(), rand_wait(),
                      1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        if (n_cmp < 1000) begin
            n_err++;
            $display("FAIL compare_count: actual %0d compared, required at least 1000", n_cmp);
        end
        if (n_err != 0) begin
            $display("FAIL overall: actual %0d mismatches, required 0", n_err);
        end else begin
            $display("PASS overall: %0d cycles compared", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL run_time_limit: actual still running, required finished");
        $fatal(1, "time limit");
    end

endmodule
